// File: rtl/fib_term_engine.sv
// Sequential Fibonacci term generator: emits F(0)..F(N-1) one term per handshake with overflow detection.
// Optional macro FIB_SAT_EN: present too-big terms saturated to all ones instead of stopping early.
module fib_term_engine #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 5
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [CNT_W-1:0] N,
    input  logic             Term_Ready,
    output logic             Busy,
    output logic             Term_Valid,
    output logic [WIDTH-1:0] Term,
    output logic [CNT_W-1:0] Term_Idx,
    output logic             Done,
    output logic             Ovf
);

    localparam int unsigned SUM_W = WIDTH + 1;

`ifdef FIB_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // A = F(k), B = F(k+1); *_big marks a value that no longer fits in WIDTH bits
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             a_big;
    logic             b_big;
    logic [CNT_W-1:0] k;
    logic [CNT_W-1:0] r;

    logic [WIDTH-1:0] a_nxt;
    logic [WIDTH-1:0] b_nxt;
    logic             a_big_nxt;
    logic             b_big_nxt;
    logic [CNT_W-1:0] k_nxt;
    logic [CNT_W-1:0] r_nxt;

    logic             busy_nxt;
    logic             valid_nxt;
    logic [WIDTH-1:0] term_nxt;
    logic [CNT_W-1:0] idx_nxt;
    logic             done_nxt;
    logic             ovf_nxt;

    logic [SUM_W-1:0] sum;
    logic             hs;
    logic             last;
    logic             stop_ovf;

    always_comb begin
        sum      = SUM_W'(a) + SUM_W'(b);
        hs       = Term_Valid & Term_Ready;
        last     = (r == CNT_W'(1));
        // Next term to present is too big and wrapping is not allowed
        stop_ovf = hs & ~last & b_big & ~SAT_EN;
    end

    // State register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (Start) begin
                    state_nxt = (N == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (hs && (last || stop_ovf)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath and output next values
    always_comb begin
        a_nxt     = a;
        b_nxt     = b;
        a_big_nxt = a_big;
        b_big_nxt = b_big;
        k_nxt     = k;
        r_nxt     = r;
        term_nxt  = Term;
        idx_nxt   = Term_Idx;
        ovf_nxt   = Ovf;
        busy_nxt  = (state_nxt != ST_IDLE);
        valid_nxt = (state_nxt == ST_RUN);
        done_nxt  = (state_nxt == ST_DONE);

        case (state)
            ST_IDLE: begin
                if (Start) begin
                    ovf_nxt = 1'b0;
                    if (N != '0) begin
                        a_nxt     = '0;
                        b_nxt     = WIDTH'(1);
                        a_big_nxt = 1'b0;
                        b_big_nxt = 1'b0;
                        k_nxt     = '0;
                        r_nxt     = N;
                        term_nxt  = '0;
                        idx_nxt   = '0;
                    end
                end
            end
            ST_RUN: begin
                if (hs) begin
                    a_nxt     = b;
                    a_big_nxt = b_big;
                    b_nxt     = sum[WIDTH-1:0];
                    b_big_nxt = sum[WIDTH] | a_big | b_big;
                    k_nxt     = k + CNT_W'(1);
                    r_nxt     = r - CNT_W'(1);
                    if (!last) begin
                        if (b_big) begin
                            ovf_nxt = 1'b1;
                            if (SAT_EN) begin
                                term_nxt = '1;
                                idx_nxt  = k + CNT_W'(1);
                            end
                        end else begin
                            term_nxt = b;
                            idx_nxt  = k + CNT_W'(1);
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            a          <= '0;
            b          <= '0;
            a_big      <= 1'b0;
            b_big      <= 1'b0;
            k          <= '0;
            r          <= '0;
            Busy       <= 1'b0;
            Term_Valid <= 1'b0;
            Term       <= '0;
            Term_Idx   <= '0;
            Done       <= 1'b0;
            Ovf        <= 1'b0;
        end else begin
            a          <= a_nxt;
            b          <= b_nxt;
            a_big      <= a_big_nxt;
            b_big      <= b_big_nxt;
            k          <= k_nxt;
            r          <= r_nxt;
            Busy       <= busy_nxt;
            Term_Valid <= valid_nxt;
            Term       <= term_nxt;
            Term_Idx   <= idx_nxt;
            Done       <= done_nxt;
            Ovf        <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_fib_term_engine.sv
// Self-checking bench for fib_term_engine: arithmetic Fibonacci model compared every cycle plus directed literal sequences.
module tb_fib_term_engine;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 5;
    localparam longint unsigned MAXV = 15;

`ifdef FIB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             Clk;
    logic             Rst_n;
    logic             Start;
    logic [CNT_W-1:0] N;
    logic             Term_Ready;
    logic             Busy;
    logic             Term_Valid;
    logic [WIDTH-1:0] Term;
    logic [CNT_W-1:0] Term_Idx;
    logic             Done;
    logic             Ovf;

    fib_term_engine #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Start      (Start),
        .N          (N),
        .Term_Ready (Term_Ready),
        .Busy       (Busy),
        .Term_Valid (Term_Valid),
        .Term       (Term),
        .Term_Idx   (Term_Idx),
        .Done       (Done),
        .Ovf        (Ovf)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;
    int done_cnt = 0;
    int stall_cnt = 0;
    int got_term[$];
    int got_idx[$];
    int exp_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    function automatic longint unsigned fib(input int k);
        longint unsigned x = 0;
        longint unsigned y = 1;
        longint unsigned t;
        for (int i = 0; i < k; i++) begin
            t = x + y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Spec-level model: phase 0 idle, 1 presenting terms, 2 done pulse
    int               m_ph = 0;
    int               m_k = 0;
    int               m_n = 0;
    logic             m_ovf = 1'b0;
    logic [WIDTH-1:0] m_term = '0;
    logic [CNT_W-1:0] m_idx = '0;

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            m_ph   <= 0;
            m_k    <= 0;
            m_n    <= 0;
            m_ovf  <= 1'b0;
            m_term <= '0;
            m_idx  <= '0;
        end else begin
            case (m_ph)
                0: if (Start) begin
                    m_ovf <= 1'b0;
                    if (N == 0) m_ph <= 2;
                    else begin
                        m_ph   <= 1;
                        m_k    <= 0;
                        m_n    <= int'(N);
                        m_term <= WIDTH'(fib(0));
                        m_idx  <= '0;
                    end
                end
                1: if (Term_Ready) begin
                    if (m_k + 1 == m_n) m_ph <= 2;
                    else if (fib(m_k + 1) > MAXV) begin
                        m_ovf <= 1'b1;
                        if (SAT) begin
                            m_k    <= m_k + 1;
                            m_term <= WIDTH'(MAXV);
                            m_idx  <= CNT_W'(m_k + 1);
                        end else m_ph <= 2;
                    end else begin
                        m_k    <= m_k + 1;
                        m_term <= WIDTH'(fib(m_k + 1));
                        m_idx  <= CNT_W'(m_k + 1);
                    end
                end
                default: m_ph <= 0;
            endcase
        end
    end

    // Per-cycle comparison against the model
    always @(negedge Clk) begin
        if (Done) done_cnt++;
        if (chk_en) begin
            chk("busy", Busy, (m_ph != 0));
            chk("valid", Term_Valid, (m_ph == 1));
            chk("done", Done, (m_ph == 2));
            chk("ovf", Ovf, m_ovf);
            chk("term", Term, m_term);
            chk("idx", Term_Idx, m_idx);
        end
    end

    // Record accepted terms and stall cycles
    always @(posedge Clk) begin
        if (Rst_n && Term_Valid && Term_Ready) begin
            got_term.push_back(int'(Term));
            got_idx.push_back(int'(Term_Idx));
        end
        if (Rst_n && Term_Valid && !Term_Ready && Term_Idx == 2) stall_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(negedge Clk);
        #1;
    endtask

    task automatic clear_log();
        got_term.delete();
        got_idx.delete();
        done_cnt  = 0;
        stall_cnt = 0;
    endtask

    task automatic start_req(input int n);
        Start = 1'b1;
        N = CNT_W'(n);
        step();
        Start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (!Busy) break;
            step();
        end
        chk("idle_wait", Busy, 0);
    endtask

    task automatic wait_idx(input int k);
        for (int i = 0; i < 40; i++) begin
            if (Term_Valid && Term_Idx == CNT_W'(k)) break;
            step();
        end
        chk("wait_idx", Term_Idx, k);
    endtask

    task automatic check_seq(input string nm, input int e[$]);
        chk({nm, "_count"}, got_term.size(), e.size());
        for (int i = 0; i < e.size() && i < got_term.size(); i++) begin
            chk({nm, "_term"}, got_term[i], e[i]);
            chk({nm, "_idx"}, got_idx[i], i);
        end
    endtask

    initial begin
        Rst_n = 1'b0;
        Start = 1'b0;
        N = '0;
        Term_Ready = 1'b1;
        step();
        step();
        chk("rst_busy", Busy, 0);
        chk("rst_valid", Term_Valid, 0);
        chk("rst_term", Term, 0);
        chk("rst_done", Done, 0);
        Rst_n = 1'b1;
        chk_en = 1'b1;
        step();

        // N=8, always ready
        clear_log();
        start_req(8);
        chk("n8_first_valid", Term_Valid, 1);
        chk("n8_first_term", Term, 0);
        wait_idle();
        exp_q = '{0, 1, 1, 2, 3, 5, 8, 13};
        check_seq("n8", exp_q);
        chk("n8_done_cnt", done_cnt, 1);
        chk("n8_ovf", Ovf, 0);
        chk("n8_last_idx", Term_Idx, 7);

        // N=10 crosses the 4-bit range
        clear_log();
        start_req(10);
        wait_idle();
`ifdef FIB_SAT_EN
        exp_q = '{0, 1, 1, 2, 3, 5, 8, 13, 15, 15};
        check_seq("n10", exp_q);
        chk("n10_last_idx", Term_Idx, 9);
`else
        exp_q = '{0, 1, 1, 2, 3, 5, 8, 13};
        check_seq("n10", exp_q);
        chk("n10_last_idx", Term_Idx, 7);
`endif
        chk("n10_ovf", Ovf, 1);
        chk("n10_done_cnt", done_cnt, 1);

        // N=4 with a 3-cycle stall at idx 2 and ignored Start while busy
        clear_log();
        start_req(4);
        chk("n4_ovf_cleared", Ovf, 0);
        wait_idx(2);
        Term_Ready = 1'b0;
        Start = 1'b1;
        N = CNT_W'(7);
        step();
        Start = 1'b0;
        step();
        step();
        chk("n4_held_term", Term, 1);
        chk("n4_held_idx", Term_Idx, 2);
        Term_Ready = 1'b1;
        wait_idle();
        step();
        step();
        exp_q = '{0, 1, 1, 2};
        check_seq("n4", exp_q);
        chk("n4_stalls", stall_cnt, 3);
        chk("n4_done_cnt", done_cnt, 1);
        chk("n4_no_restart", Busy, 0);

        // N=0: immediate Done, no term
        clear_log();
        start_req(0);
        chk("n0_busy", Busy, 1);
        chk("n0_done", Done, 1);
        chk("n0_valid", Term_Valid, 0);
        step();
        chk("n0_busy_after", Busy, 0);
        chk("n0_count", got_term.size(), 0);
        chk("n0_done_cnt", done_cnt, 1);

        // Asynchronous reset in the middle of a sequence
        clear_log();
        start_req(8);
        wait_idx(3);
        chk("mid_term_pre", Term, 2);
        #2 Rst_n = 1'b0;
        #1;
        chk("arst_busy", Busy, 0);
        chk("arst_valid", Term_Valid, 0);
        chk("arst_term", Term, 0);
        chk("arst_idx", Term_Idx, 0);
        chk("arst_done", Done, 0);
        step();
        step();
        Rst_n = 1'b1;
        step();
        chk("arst_no_done", done_cnt, 0);
        clear_log();
        start_req(2);
        wait_idle();
        exp_q = '{0, 1};
        check_seq("n2", exp_q);
        chk("n2_done_cnt", done_cnt, 1);

        step();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fib_term_engine.md
Name: fib_term_engine

Overview:
- Sequential Fibonacci term generator for the calculator datapath.
- Produces the series F(0), F(1), … F(N-1) one term per accepted handshake.
- Directly feeds the output register stage (WIDTH-bit D/Q flop bank): Term drives its D input.
- Owns the start/done control, term indexing and overflow detection.

Parameters:
WIDTH, 4, term width in bits; must match the downstream register SIZE.
CNT_W, 5, width of N and Term_Idx; maximum request is 2^CNT_W-1 terms.

Ports:
Clk  input  1  system clock, rising edge.
Rst_n  input  1  asynchronous active-low reset.
Start  input  1  request pulse; sampled only in IDLE.
N  input  CNT_W  number of terms to emit; captured on accepted Start.
Term_Ready  input  1  downstream can accept Term this cycle.
Busy  output  1  high in RUN and DONE states.
Term_Valid  output  1  Term/Term_Idx hold a valid term.
Term  output  WIDTH  current Fibonacci term.
Term_Idx  output  CNT_W  index k of the presented term.
Done  output  1  one-cycle pulse at end of sequence.
Ovf  output  1  sticky overflow flag; cleared on next accepted Start.

Behaviour:
- Clock and reset: one clock (Clk); reset is asynchronous and active-low (Rst_n).
- Reset values: state=IDLE; Busy, Term_Valid, Done, Ovf = 0; Term, Term_Idx = 0.
- Internal registers: A=F(k), B=F(k+1), each with a "too big" flag; remaining count R.
- FSM states: IDLE, RUN, DONE.
- IDLE, Start=1, N=0: go to DONE; clear Ovf; no term emitted.
- IDLE, Start=1, N>0: load A=0, B=1, k=0, R=N; clear Ovf; go to RUN. The first term is valid the cycle after Start.
- RUN:
  - Term_Valid=1, Term=A, Term_Idx=k.
  - Handshake occurs when Term_Valid & Term_Ready.
  - Term and Term_Idx stay stable while Term_Ready=0.
  - On handshake: A<=B, B<=A+B computed at WIDTH+1 bits (carry or an incoming too-big flag sets B's too-big flag), k<=k+1, R<=R-1.
  - If R==1 at the handshake, go to DONE.
- Overflow: when the term about to be presented (A) is too big, i.e. F(k) > 2^WIDTH-1:
  - Ovf<=1.
  - Behaviour in that case is selected by FIB_SAT_EN (see Optional Feature).
- DONE: Done=1 for exactly one cycle, Term_Valid=0, then go to IDLE. Term and Term_Idx keep their last values.
- Start while Busy is ignored; N is not re-sampled.
- Term_Ready is a don't-care when Term_Valid=0.
- Rst_n asserted mid-sequence: immediate return to reset values. No Done pulse is issued.
- Arithmetic is unsigned. No term is ever silently wrapped modulo 2^WIDTH.

Optional Feature:
Macro FIB_SAT_EN.
- Undefined (default):
  - On overflow, the too-big term is never presented.
  - The engine sets Ovf and goes straight to DONE (Done pulse).
  - Term_Idx holds the index of the last good term.
- Defined:
  - The engine continues the sequence.
  - Every too-big term is presented as Term = all ones (2^WIDTH-1) with normal handshakes and indices.
  - Ovf is set at the first saturated term and stays set.
  - Done fires after all N terms.

Test Plan:
- Reset, then Start with N=8, Term_Ready=1 -> terms 0,1,1,2,3,5,8,13 on 8 consecutive cycles with idx 0..7, Done pulse next cycle, Ovf=0.
- N=10, macro off -> terms 0..13 (idx 0..7), then Ovf=1 and a Done pulse; no Term_Valid for idx 8; Term_Idx stays 7.
- N=10, FIB_SAT_EN defined -> 0,1,1,2,3,5,8,13,15,15 (idx 0..9), Ovf rises with idx 8, Done after idx 9.
- N=4 with Term_Ready low for 3 cycles at idx 2 -> Term=1, idx=2 held stable for 3 cycles, then 2 at idx 3, Done; Start pulses during Busy are ignored.
- N=0 -> Done one cycle after Start, Term_Valid never asserted, Busy high for one cycle.
- Rst_n low during idx 3 of N=8 -> outputs return to zero asynchronously, no Done; a new Start with N=2 -> 0,1, then Done.
